// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: HUB75 row scanner with double-buffered RGB565 framebuffer and frame-level PWM brightness
module hub75_bcm_scanner #(
  parameter int COLS = 64,
  parameter int ROW_ADDR_BITS = 4,
  parameter int PWM_BITS = 5,
  parameter int CLK_DIV = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [ROW_ADDR_BITS+$clog2(COLS):0] wr_addr,
  input  logic [15:0]                         wr_data,
  input  logic                                swap_req,
  output logic                                swap_ack,
  output logic                                frame_start,
  output logic [ROW_ADDR_BITS-1:0]            row_sel,
  output logic                                clkout,
  output logic                                stb,
  output logic                                oe,
  output logic                                r0,
  output logic                                g0,
  output logic                                b0,
  output logic                                r1,
  output logic                                g1,
  output logic                                b1
);
  localparam int CB = $clog2(COLS);
  localparam int AW = 1 + ROW_ADDR_BITS + CB;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [CB-1:0] COL_LAST = CB'(COLS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [ROW_ADDR_BITS-1:0] ROW_LAST = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(2 ** PWM_BITS - 2);

  typedef enum logic [2:0] {SHIFT, BLANK, LATCH, ROWADV, UNBLANK} state_t;

  state_t                     state;
  logic [CB-1:0]              col;
  logic [CB-1:0]              rd_col;
  logic [DW-1:0]              div;
  logic [DW-1:0]              div_nxt;
  logic [ROW_ADDR_BITS-1:0]   shift_row;
  logic [PWM_BITS-1:0]        pwm_cnt;
  logic                       front;
  logic                       swap_pend;
  logic [AW-1:0]              rd_addr;
  logic [15:0]                rd_u;
  logic [15:0]                rd_l;
  logic [15:0]                mem_u [2**AW];
  logic [15:0]                mem_l [2**AW];

  function automatic logic [2:0] px(input logic [15:0] p, input logic [PWM_BITS-1:0] c);
    return {p[15-:PWM_BITS] > c, p[10-:PWM_BITS] > c, p[4-:PWM_BITS] > c};
  endfunction

  // Row/front/pwm already hold next-row values during ROWADV, so the col 0 prefetch there is correct
  assign rd_col  = (state == SHIFT) ? col + 1'b1 : '0;
  assign rd_addr = {front, shift_row, rd_col};
  assign div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en && !wr_addr[AW-1]) mem_u[{~front, wr_addr[AW-2:0]}] <= wr_data;
    if (wr_en && wr_addr[AW-1]) mem_l[{~front, wr_addr[AW-2:0]}] <= wr_data;
    rd_u <= mem_u[rd_addr];
    rd_l <= mem_l[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SHIFT;
      col         <= '0;
      div         <= '0;
      shift_row   <= '0;
      pwm_cnt     <= '0;
      front       <= 1'b0;
      swap_pend   <= 1'b0;
      row_sel     <= '0;
      clkout      <= 1'b0;
      stb         <= 1'b0;
      oe          <= 1'b1;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      {r0, g0, b0, r1, g1, b1} <= '0;
    end else begin
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      swap_pend   <= swap_pend | swap_req;
      case (state)
        SHIFT: begin
          div    <= div_nxt;
          clkout <= div_nxt >= DIV_HALF;
          if (div == DIV_LAST) begin
            col <= col + 1'b1;
            if (col == COL_LAST) begin
              state <= BLANK;
              oe    <= 1'b1;
            end else begin
              {r0, g0, b0, r1, g1, b1} <= {px(rd_u, pwm_cnt), px(rd_l, pwm_cnt)};
            end
          end
        end
        BLANK: begin
          state <= LATCH;
          stb   <= 1'b1;
        end
        LATCH: begin
          state       <= ROWADV;
          stb         <= 1'b0;
          row_sel     <= shift_row;
          shift_row   <= shift_row + 1'b1;
          frame_start <= (shift_row == '0) && (pwm_cnt == '0);
          if (shift_row == ROW_LAST) begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            if (pwm_cnt == PWM_LAST && swap_pend) begin
              front     <= ~front;
              swap_ack  <= 1'b1;
              swap_pend <= swap_req;
            end
          end
        end
        ROWADV: begin
          state <= UNBLANK;
          oe    <= 1'b0;
        end
        UNBLANK: begin
          state <= SHIFT;
          {r0, g0, b0, r1, g1, b1} <= {px(rd_u, pwm_cnt), px(rd_l, pwm_cnt)};
        end
        default: state <= SHIFT;
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// tb_hub75_bcm_scanner: directed checks of row timing, PWM compare, swap handshake and reset on three parameter sets
module tb_hub75_bcm_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_ack, a_fs, a_ck, a_stb, a_oe, a_r0, a_g0, a_b0, a_r1, a_g1, a_b1;
  logic [3:0] a_row;
  logic       b_ack, b_fs, b_ck, b_stb, b_oe, b_r0, b_g0, b_b0, b_r1, b_g1, b_b1;
  logic [2:0] b_row;
  logic       c_ack, c_fs, c_ck, c_stb, c_oe, c_r0, c_g0, c_b0, c_r1, c_g1, c_b1;
  logic [0:0] c_row;
  logic       c_wr_en = 1'b0;
  logic [4:0] c_wr_addr = '0;
  logic [15:0] c_wr_data = '0;
  logic       c_swap = 1'b0;

  hub75_bcm_scanner dut (
    .clk(clk), .rst(rst), .wr_en(1'b0), .wr_addr(11'd0), .wr_data(16'd0), .swap_req(1'b0),
    .swap_ack(a_ack), .frame_start(a_fs), .row_sel(a_row), .clkout(a_ck), .stb(a_stb), .oe(a_oe),
    .r0(a_r0), .g0(a_g0), .b0(a_b0), .r1(a_r1), .g1(a_g1), .b1(a_b1));

  hub75_bcm_scanner #(.COLS(32), .ROW_ADDR_BITS(3), .PWM_BITS(3), .CLK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .wr_en(1'b0), .wr_addr(9'd0), .wr_data(16'd0), .swap_req(1'b0),
    .swap_ack(b_ack), .frame_start(b_fs), .row_sel(b_row), .clkout(b_ck), .stb(b_stb), .oe(b_oe),
    .r0(b_r0), .g0(b_g0), .b0(b_b0), .r1(b_r1), .g1(b_g1), .b1(b_b1));

  hub75_bcm_scanner #(.COLS(8), .ROW_ADDR_BITS(1), .PWM_BITS(5), .CLK_DIV(2)) dut_c (
    .clk(clk), .rst(rst), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .swap_req(c_swap),
    .swap_ack(c_ack), .frame_start(c_fs), .row_sel(c_row), .clkout(c_ck), .stb(c_stb), .oe(c_oe),
    .r0(c_r0), .g0(c_g0), .b0(c_b0), .r1(c_r1), .g1(c_g1), .b1(c_b1));

  int n_tests = 0;
  int n_fail = 0;
  int cyc;
  int oe_first, b_oe_first, stb_n, stb_cyc, a_rise, b_rise, rs130, fs_n, fs_cyc;
  int b_rs7, b_rs0, b_fs_n, b_fs_cyc, ack_n, ack_cyc, up0, up_other, r1_n, r1_15, r1_16, lo_other, gb1;
  logic a_prev, b_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    oe_first = -1; b_oe_first = -1; stb_n = 0; stb_cyc = -1; a_rise = 0; b_rise = 0; rs130 = -1;
    fs_n = 0; fs_cyc = -1; b_rs7 = -1; b_rs0 = -1; b_fs_n = 0; b_fs_cyc = -1; ack_n = 0; ack_cyc = -1;
    up0 = 0; up_other = 0; r1_n = 0; r1_15 = -1; r1_16 = -1; lo_other = 0; gb1 = 0;
    a_prev = 1'b0; b_prev = 1'b0;
  endtask

  // Small-panel row 0 of PWM step s shifts at 1240+40*s; pixel c sampled in the second cycle of its period
  task automatic sample();
    int u, s, p, c, row;
    if (!a_oe && oe_first < 0) oe_first = cyc;
    if (!b_oe && b_oe_first < 0) b_oe_first = cyc;
    if (a_stb) begin stb_n++; stb_cyc = cyc; end
    if (cyc <= 131 && a_ck && !a_prev) a_rise++;
    if (cyc <= 131 && b_ck && !b_prev) b_rise++;
    a_prev = a_ck; b_prev = b_ck;
    if (cyc == 130) rs130 = int'(a_row);
    if (a_fs) begin fs_n++; fs_cyc = cyc; end
    if (cyc == 1054) b_rs7 = int'(b_row);
    if (cyc == 1186) b_rs0 = int'(b_row);
    if (b_fs) begin b_fs_n++; b_fs_cyc = cyc; end
    if (c_ack) begin ack_n++; ack_cyc = cyc; end
    if (cyc >= 1240 && cyc < 2480) begin
      u = cyc - 1240; s = u / 40; p = u % 40; row = p / 20;
      if ((p % 20) < 16 && (p % 2) == 1) begin
        c = (p % 20) / 2;
        if (row == 0 && c == 0) up0 += int'({c_r0, c_g0, c_b0} == 3'b111);
        else up_other += int'(c_r0 | c_g0 | c_b0);
        if (row == 0 && c == 2) begin
          r1_n += int'(c_r1);
          if (s == 15) r1_15 = int'(c_r1);
          if (s == 16) r1_16 = int'(c_r1);
        end else lo_other += int'(c_r1);
        gb1 += int'(c_g1 | c_b1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    clear_rec();
    sample();
    check("rst_row_sel", a_row, 0);
    check("rst_oe", a_oe, 1);
    check("rst_stb", a_stb, 0);
    check("rst_clkout", a_ck, 0);
    check("rst_data", {a_r0, a_g0, a_b0, a_r1, a_g1, a_b1}, 0);
    check("rst_flags", {a_ack, a_fs, c_ack, c_fs}, 0);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check_swap_data(input string tag);
    check({tag, "_ack_n"}, ack_n, 1);
    check({tag, "_ack_cyc"}, ack_cyc, 1238);
    check({tag, "_col0_lit"}, up0, 31);
    check({tag, "_up_other"}, up_other, 0);
    check({tag, "_r1_lit"}, r1_n, 16);
    check({tag, "_r1_s15"}, r1_15, 1);
    check({tag, "_r1_s16"}, r1_16, 0);
    check({tag, "_lo_other"}, lo_other, 0);
    check({tag, "_gb1"}, gb1, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();
    run_to(200);
    check("t1_oe_first", oe_first, 131);
    check("t1_stb_n", stb_n, 1);
    check("t1_stb_cyc", stb_cyc, 129);
    check("t1_rises", a_rise, 64);
    check("t1_row_sel", rs130, 0);
    check("t1_fs_cyc", fs_cyc, 130);
    check("t6_oe_first", b_oe_first, 131);
    check("t6_rises", b_rise, 32);
    for (int a = 0; a < 32; a++) begin
      c_wr_en = 1'b1;
      c_wr_addr = 5'(a);
      c_wr_data = (a == 0) ? 16'hFFFF : (a == 18) ? 16'h8000 : 16'h0000;
      tick();
    end
    c_wr_en = 1'b0;
    run_to(300);
    c_swap = 1'b1; tick(); c_swap = 1'b0;
    run_to(310);
    c_swap = 1'b1; tick(); c_swap = 1'b0;
    run_to(2480);
    check_swap_data("t2");
    run_to(7600);
    check("t6_row7", b_rs7, 7);
    check("t6_row_wrap", b_rs0, 0);
    check("t6_fs_n", b_fs_n, 2);
    check("t6_fs_cyc", b_fs_cyc, 7522);
    while (cyc % 2112 != 974 && cyc < 12000) tick();
    check("t5_pre_row_sel", a_row, 6);
    check("t5_pre_oe", a_oe, 0);
    do_reset();
    run_to(5);
    c_swap = 1'b1; tick(); c_swap = 1'b0;
    run_to(2480);
    check("t5_oe_first", oe_first, 131);
    check("t5_rises", a_rise, 64);
    check("t5_row_sel", rs130, 0);
    check_swap_data("t5");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hub75_bcm_scanner.md
Name: hub75_bcm_scanner

Overview:
Parametrised HUB75 panel scanner: drives two half-panel RGB shift chains (upper/lower), row-select address, shift clock, strobe and output-enable from an internal double-buffered RGB565 framebuffer. Each row pair is shifted while the previous row is displayed. Brightness uses a frame-level PWM compare of configurable depth. A host write port fills the back buffer, and a swap request exchanges buffers at a full PWM-cycle boundary so the panel never shows tearing.

Parameters:
COLS, 64, pixels per row per chain; power of two, ≥8.
ROW_ADDR_BITS, 4, row-select width; 2^ROW_ADDR_BITS row pairs per panel.
PWM_BITS, 5, brightness depth per channel, 1..5; MSBs of each RGB565 field compared.
CLK_DIV, 2, sysclk cycles per shifted pixel; even, ≥2.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
wr_en  in  1  back-buffer write strobe.
wr_addr  in  1+ROW_ADDR_BITS+log2(COLS)  {half, row, col}; half=0 upper chain.
wr_data  in  16  RGB565 pixel.
swap_req  in  1  single-cycle pulse requesting a buffer swap.
swap_ack  out  1  one-cycle pulse when the swap takes effect.
frame_start  out  1  one-cycle pulse when row 0 of PWM step 0 is latched.
row_sel  out  ROW_ADDR_BITS  panel row address (A..D).
clkout  out  1  panel shift clock.
stb  out  1  panel latch strobe, active-high.
oe  out  1  panel output enable, active-low (1 = blanked).
r0,g0,b0  out  1 each  upper-chain data.
r1,g1,b1  out  1 each  lower-chain data.

Behaviour:
- Reset values: row_sel=0, clkout=0, stb=0, oe=1, all data outputs 0, swap_ack=0, frame_start=0, pwm_cnt=0, front buffer=0, no swap pending, FSM=SHIFT at col 0, shifting row 0. Memory contents are not cleared. Reset asserted mid-row aborts it immediately and the next cycle is in the reset state.
- Memory: 2 buffers × 2 halves × 2^ROW_ADDR_BITS × COLS × 16 bits. Reads have 1-cycle latency. The scanner prefetches so that column k's data is valid during pixel period k.
- SHIFT:
  - COLS pixel periods of CLK_DIV cycles each.
  - Data outputs update on the first cycle of each period.
  - clkout=0 for the first CLK_DIV/2 cycles of the period, then 1 for the rest; rising edge is mid-period.
  - clkout stays 0 outside SHIFT.
- Row sequence after the last pixel period: BLANK (oe=1, 1 cycle) → LATCH (stb=1, 1 cycle) → ROWADV (row_sel ← just-shifted row, 1 cycle) → UNBLANK (oe←0, 1 cycle) → SHIFT next row. Row period = COLS*CLK_DIV+4 cycles (132 at defaults).
- oe stays 1 from reset until the first UNBLANK.
- Pixel compare: channel field MSBs v (red[15:11], green[10:5], blue[4:0], top PWM_BITS bits each). Output = (v > pwm_cnt).
- pwm_cnt runs 0..2^PWM_BITS-2, then wraps to 0. Full-scale is therefore always lit and zero is never lit.
- pwm_cnt advances in ROWADV when the latched row is the last row (2^ROW_ADDR_BITS-1). The shifted row index wraps to 0 at the same time.
- frame_start pulses in ROWADV when row 0 is latched and pwm_cnt=0.
- Swap:
  - swap_req sets a pending flag.
  - Further requests while pending are absorbed; there is one pending swap at most.
  - The swap executes in the ROWADV cycle where pwm_cnt wraps to 0: the front buffer toggles, swap_ack pulses, and pending clears.
  - swap_req in the same cycle as an executing swap sets pending again for the next wrap.
- Writes always target the current back buffer. A write in the swap-execute cycle lands in the old back buffer, which becomes front.
- Write and scanner read in the same cycle never conflict, since they address different buffers.

Test Plan:
1. Reset, idle 200 cycles → oe=1 until cycle 131 (UNBLANK), stb high exactly 1 cycle at cycle 129, row_sel=0 after ROWADV, 64 clkout rising edges per row.
2. Write 0xFFFF to back upper row 0 col 0, swap_req, run one full PWM cycle (31×16×132=65472 cycles) → swap_ack once at the wrap; afterwards r0/g0/b0=1 for col 0 on every PWM step, all other columns 0.
3. Pixel red field=16 (PWM_BITS=5), lower half → r1 high on pwm_cnt 0..15 (16 of 31 steps), low on 16..30; g1/b1 never high.
4. Two swap_req pulses 10 cycles apart within one PWM cycle → exactly one swap_ack; front buffer toggled once.
5. Assert rst for 1 cycle mid-SHIFT of row 7 → next cycle all outputs at reset values, row scanning restarts at row 0, memory data still displayed after re-swap.
6. Parameter set COLS=32, ROW_ADDR_BITS=3, PWM_BITS=3, CLK_DIV=4 → row period 132 cycles, 32 clkout edges per row, row_sel wraps 7→0, pwm_cnt wraps 6→0.
